// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: FSM state encoding and
// default stream word width.
package mips_pkg;

  localparam int DEF_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ICNT,
    S_IWR,
    S_DCNT,
    S_DWR,
    S_RUN,
    S_ERR
  } state_t;

endpackage

// File: rtl/mips_load_channel.sv
// One memory fill channel: count check, remaining-word counter, auto-incrementing
// address and a registered write port (strobe one cycle after the accepted beat).
module mips_load_channel #(
  parameter int                WORD_W = 32,
  parameter int                ADDR_W = 7,
  parameter int                CNT_W  = 8,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              cnt_load,
  input  logic              wr_beat,
  input  logic [WORD_W-1:0] word,
  output logic              cnt_bad,
  output logic              cnt_zero,
  output logic              last,
  output logic [WORD_W-1:0] wdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we
);

  // Depth held one bit wider than the word so the count compare never truncates.
  localparam logic [WORD_W:0] DEPTH = {{WORD_W{1'b0}}, 1'b1} << ADDR_W;

  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  remaining;

  assign cnt_bad  = {1'b0, word} > DEPTH;
  assign cnt_zero = (word == '0);
  assign last     = (remaining == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr <= BASE;
      addr      <= BASE;
      wdata     <= '0;
      we        <= 1'b0;
      remaining <= '0;
    end else begin
      we <= wr_beat;
      if (reload) begin
        next_addr <= BASE;
        addr      <= BASE;
      end else if (wr_beat) begin
        wdata     <= word;
        addr      <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (cnt_load) remaining <= word[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Stream-driven preload engine: [N_I][instr words][N_D][data words] fills
// instruction then data memory, then releases the core via core_run.
module mips_program_loader
  import mips_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int IADDR_W = 7,
  parameter int DADDR_W = 7,
  parameter int IBASE   = 0,
  parameter int DBASE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic [IADDR_W-1:0] imem_addr,
  output logic               imem_we,
  output logic [WORD_W-1:0]  dmem_wdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic               core_run,
  output logic               error
);

  localparam int CNT_W = ((IADDR_W > DADDR_W) ? IADDR_W : DADDR_W) + 1;

  state_t state, state_nx;
  logic   reload;
  logic   i_cnt_load, i_wr_beat, i_bad, i_zero, i_last;
  logic   d_cnt_load, d_wr_beat, d_bad, d_zero, d_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    reload     = 1'b0;
    i_cnt_load = 1'b0;
    i_wr_beat  = 1'b0;
    d_cnt_load = 1'b0;
    d_wr_beat  = 1'b0;
    unique case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          reload   = 1'b1;
          state_nx = S_ICNT;
        end
      end
      S_ICNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (i_bad)       state_nx = S_ERR;
          else if (i_zero) state_nx = S_DCNT;
          else begin
            i_cnt_load = 1'b1;
            state_nx   = S_IWR;
          end
        end
      end
      S_IWR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          i_wr_beat = 1'b1;
          if (i_last) state_nx = S_DCNT;
        end
      end
      S_DCNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (d_bad)       state_nx = S_ERR;
          else if (d_zero) state_nx = S_RUN;
          else begin
            d_cnt_load = 1'b1;
            state_nx   = S_DWR;
          end
        end
      end
      S_DWR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          d_wr_beat = 1'b1;
          if (d_last) state_nx = S_RUN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign core_run = (state == S_RUN);
  assign error    = (state == S_ERR);

  mips_load_channel #(
    .WORD_W(WORD_W), .ADDR_W(IADDR_W), .CNT_W(CNT_W), .BASE(IADDR_W'(IBASE))
  ) u_ichan (
    .clk(clk), .reset(reset), .reload(reload), .cnt_load(i_cnt_load),
    .wr_beat(i_wr_beat), .word(in_word), .cnt_bad(i_bad), .cnt_zero(i_zero),
    .last(i_last), .wdata(imem_wdata), .addr(imem_addr), .we(imem_we)
  );

  mips_load_channel #(
    .WORD_W(WORD_W), .ADDR_W(DADDR_W), .CNT_W(CNT_W), .BASE(DADDR_W'(DBASE))
  ) u_dchan (
    .clk(clk), .reset(reset), .reload(reload), .cnt_load(d_cnt_load),
    .wr_beat(d_wr_beat), .word(in_word), .cnt_bad(d_bad), .cnt_zero(d_zero),
    .last(d_last), .wdata(dmem_wdata), .addr(dmem_addr), .we(dmem_we)
  );

endmodule

// File: tb/tb_mips_program_loader.sv
// Self-checking bench: random and directed load streams compared against a
// stream-parsing model of the expected memory images and completion status.
module tb_mips_program_loader;

  localparam int IADDR_W = 7;
  localparam int DADDR_W = 7;
  localparam int IDEPTH  = 1 << IADDR_W;
  localparam int DDEPTH  = 1 << DADDR_W;
  localparam int IBASE   = 0;
  localparam int DBASE   = 0;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [31:0]        in_word = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        imem_wdata, dmem_wdata;
  logic [IADDR_W-1:0] imem_addr;
  logic [DADDR_W-1:0] dmem_addr;
  logic               imem_we, dmem_we, core_run, error;

  int total = 0;
  int bad   = 0;

  int          imem_cnt [IDEPTH];
  int          dmem_cnt [DDEPTH];
  logic [31:0] imem_data[IDEPTH];
  logic [31:0] dmem_data[DDEPTH];
  int          overlap = 0;
  logic [31:0] stim[$];

  mips_program_loader #(
    .WORD_W(32), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W), .IBASE(IBASE), .DBASE(DBASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .imem_wdata(imem_wdata), .imem_addr(imem_addr),
    .imem_we(imem_we), .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .core_run(core_run), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural memories: record every strobed write.
  always @(posedge clk) begin
    if (imem_we) begin
      imem_cnt[imem_addr]++;
      imem_data[imem_addr] = imem_wdata;
    end
    if (dmem_we) begin
      dmem_cnt[dmem_addr]++;
      dmem_data[dmem_addr] = dmem_wdata;
    end
    if (imem_we && dmem_we) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_err_clr", {31'b0, error}, 32'd0);
    check("start_run_drop", {31'b0, core_run}, 32'd0);
    check("start_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    check("run_early", {31'b0, core_run}, 32'd0);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  // Parse stim by the stream rules, drive it, then compare outcome and memories.
  task automatic run_load(input int gap_pct, input int gap_at, input int gap_len);
    logic [31:0] iw[$], dw[$];
    bit          exp_err = 1'b0;
    int          icnt0[IDEPTH], dcnt0[DDEPTH];
    int          ov0, idx, nbad_i, nbad_d, di, dd;
    logic [31:0] ci, cd;
    logic [31:0] exp_i[IDEPTH], exp_d[DDEPTH];
    int          ecnt_i[IDEPTH], ecnt_d[DDEPTH];

    icnt0 = imem_cnt;
    dcnt0 = dmem_cnt;
    ov0   = overlap;
    idx   = 0;
    ci    = stim[idx++];
    if (ci > 32'(IDEPTH)) exp_err = 1'b1;
    else begin
      for (int i = 0; i < int'(ci); i++) iw.push_back(stim[idx++]);
      cd = stim[idx++];
      if (cd > 32'(DDEPTH)) exp_err = 1'b1;
      else for (int i = 0; i < int'(cd); i++) dw.push_back(stim[idx++]);
    end

    pulse_start();
    for (int k = 0; k < idx; k++) begin
      if (k == gap_at)
        repeat (gap_len) begin @(negedge clk); in_valid = 1'b0; in_word = $urandom; end
      else if (k > 0 && int'($urandom_range(99)) < gap_pct)
        repeat ($urandom_range(3, 1)) begin @(negedge clk); in_valid = 1'b0; in_word = $urandom; end
      send_word(stim[k]);
    end
    @(negedge clk);
    in_valid = 1'b0;

    if (exp_err) begin
      check("err_flag", {31'b0, error}, 32'd1);
      check("err_ready", {31'b0, in_ready}, 32'd0);
      check("err_run", {31'b0, core_run}, 32'd0);
    end else begin
      check("run_flag", {31'b0, core_run}, 32'd1);
      check("run_err", {31'b0, error}, 32'd0);
      check("run_ready", {31'b0, in_ready}, 32'd0);
      check("last_dwe", {31'b0, dmem_we}, {31'b0, dw.size() > 0});
    end
    repeat (3) @(negedge clk);

    for (int a = 0; a < IDEPTH; a++) ecnt_i[a] = 0;
    for (int a = 0; a < DDEPTH; a++) ecnt_d[a] = 0;
    foreach (iw[i]) begin
      ecnt_i[(IBASE + i) % IDEPTH]++;
      exp_i[(IBASE + i) % IDEPTH] = iw[i];
    end
    foreach (dw[i]) begin
      ecnt_d[(DBASE + i) % DDEPTH]++;
      exp_d[(DBASE + i) % DDEPTH] = dw[i];
    end
    nbad_i = 0; nbad_d = 0; di = 0; dd = 0;
    for (int a = 0; a < IDEPTH; a++) begin
      di += imem_cnt[a] - icnt0[a];
      if (imem_cnt[a] - icnt0[a] != ecnt_i[a]) nbad_i++;
      else if (ecnt_i[a] != 0 && imem_data[a] !== exp_i[a]) nbad_i++;
    end
    for (int a = 0; a < DDEPTH; a++) begin
      dd += dmem_cnt[a] - dcnt0[a];
      if (dmem_cnt[a] - dcnt0[a] != ecnt_d[a]) nbad_d++;
      else if (ecnt_d[a] != 0 && dmem_data[a] !== exp_d[a]) nbad_d++;
    end
    check("imem_writes", 32'(di), 32'(iw.size()));
    check("dmem_writes", 32'(dd), 32'(dw.size()));
    check("imem_map", 32'(nbad_i), 32'd0);
    check("dmem_map", 32'(nbad_d), 32'd0);
    check("we_overlap", 32'(overlap - ov0), 32'd0);
  endtask

  task automatic random_stim(input bit allow_bad);
    int ni, nd;
    stim.delete();
    ni = $urandom_range(12);
    nd = $urandom_range(12);
    if (allow_bad && $urandom_range(5) == 0) begin
      stim.push_back(32'(IDEPTH + 1) + $urandom_range(1000));
      return;
    end
    stim.push_back(32'(ni));
    repeat (ni) stim.push_back($urandom);
    if (allow_bad && $urandom_range(5) == 0) begin
      stim.push_back(32'h1000_0000 | 32'($urandom_range(DDEPTH)));
      return;
    end
    stim.push_back(32'(nd));
    repeat (nd) stim.push_back($urandom);
  endtask

  initial begin
    for (int a = 0; a < IDEPTH; a++) begin imem_cnt[a] = 0; imem_data[a] = '0; end
    for (int a = 0; a < DDEPTH; a++) begin dmem_cnt[a] = 0; dmem_data[a] = '0; end

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_iwe", {31'b0, imem_we}, 32'd0);
    check("rst_dwe", {31'b0, dmem_we}, 32'd0);
    check("rst_run", {31'b0, core_run}, 32'd0);
    check("rst_err", {31'b0, error}, 32'd0);
    check("rst_iaddr", 32'(imem_addr), 32'(IBASE));
    check("rst_daddr", 32'(dmem_addr), 32'(DBASE));
    check("rst_iwdata", imem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, in_ready}, 32'd0);

    stim = '{32'd2, 32'h2022_0003, 32'h8C01_0000, 32'd1, 32'h0000_000C};
    run_load(0, -1, 0);
    run_load(0, 2, 3);

    stim = '{32'd0, 32'd0};
    run_load(0, -1, 0);

    stim = '{32'd129};
    run_load(0, -1, 0);

    stim = '{32'h1000_0000};
    run_load(0, -1, 0);

    stim.delete();
    stim.push_back(32'd128);
    repeat (128) stim.push_back($urandom);
    stim.push_back(32'd0);
    run_load(0, -1, 0);

    stim = '{32'd1, 32'hDEAD_BEEF, 32'd129};
    run_load(20, -1, 0);

    stim.delete();
    stim.push_back(32'd1);
    stim.push_back(32'h1234_5678);
    stim.push_back(32'd128);
    repeat (128) stim.push_back($urandom);
    run_load(10, -1, 0);

    pulse_start();
    send_word(32'd3);
    send_word(32'hAAAA_0001);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = 32'hAAAA_0002;
    check("pre_reset_we", {31'b0, imem_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_iwe", {31'b0, imem_we}, 32'd0);
    check("mid_rst_run", {31'b0, core_run}, 32'd0);
    check("mid_rst_iaddr", 32'(imem_addr), 32'(IBASE));
    check("mid_rst_iwdata", imem_wdata, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    stim = '{32'd2, 32'h2022_0003, 32'h8C01_0000, 32'd1, 32'h0000_000C};
    run_load(0, -1, 0);

    for (int n = 0; n < 20; n++) begin
      random_stim(1'b1);
      run_load(30, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
